// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI byte-line transmitter/receiver
//               pair. Holds the receive FSM state encoding, the byte width and
//               the three-cycle symbol phase levels (MARK / DATA / SPACE).
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Receive decoder states. IDLE also absorbs the MARK of bit 0.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        SPACE = 2'd2,
        NEXT  = 2'd3
    } spi_state_t;

    localparam int SPI_BITS       = 8;
    localparam int SPI_SYM_CYCLES = 3;

    // Line levels for the fixed symbol phases and the inter-byte idle.
    localparam logic SPI_MARK_LVL  = 1'b1;
    localparam logic SPI_SPACE_LVL = 1'b0;
    localparam logic SPI_IDLE_LVL  = 1'b0;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_fifo
// Description : Small show-ahead byte buffer between the SPI frame decoder and
//               its consumer. 2^FIFO_AW entries, synchronous write and pop,
//               asynchronous active-high flush.
// Ports       : clk, rst        - clock, async active-high reset
//               wr_en, wr_data  - push request (dropped when full w/o pop)
//               rd_en           - pop request (ignored when empty)
//               rd_data         - head entry (0 when empty)
//               full, empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_fifo #(
    parameter int FIFO_AW = 2,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int C_DEPTH = 1 << FIFO_AW;

    // One extra pointer bit distinguishes full from empty.
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [C_DEPTH];
    logic               w_pop;
    logic               w_push;
    logic [FIFO_AW:0]   c_ptr_one;

    assign c_ptr_one = {{FIFO_AW{1'b0}}, 1'b1};

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

    assign w_pop  = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_push = wr_en & (~full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= wr_data;
    end

    // Stale entries are hidden so an empty/flushed buffer presents zero.
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];

endmodule : spi_rx_fifo
`default_nettype wire

// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_rx
// Description : Receive decoder for the SPI byte line. Each bit is a three
//               cycle MARK(1) / DATA(bit) / SPACE(0) symbol, LSB first, qualified
//               by the active-low transmitter enable. Reassembled bytes are
//               presented to the consumer; malformed symbols pulse frame_err.
//               Build option SPI_RX_FIFO_EN adds a 2^FIFO_AW-entry show-ahead
//               buffer (rx_valid = not empty, rd_en pops, overflow on drop).
//               Without it rx_valid is a one-cycle pulse and rd_en is ignored.
// Ports       : clk, rst    - clock, async active-high reset
//               line_in     - serial data line
//               en_n_in     - transmitter enable, active low
//               rd_en       - consumer pop (buffered build only)
//               rx_data     - received byte
//               rx_valid    - byte available
//               frame_err   - one-cycle pulse on a malformed symbol
//               overflow    - one-cycle pulse when a byte is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_rx #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_in,
    input  logic       en_n_in,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overflow
);

    import spi_pkg::*;

    localparam logic [2:0] C_LAST_BIT = 3'(SPI_BITS - 1);

    spi_state_t          r_state;
    spi_state_t          w_next_state;
    logic [2:0]          r_bit_cnt;
    logic [SPI_BITS-1:0] r_shift;
    logic                r_frame_err;

    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_shift_en;
    logic                w_byte_done;
    logic                w_frame_err;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // FSM next state. A high enable is the transmitter's hold condition and
    // overrides every line check.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (en_n_in) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (line_in == SPI_MARK_LVL) w_next_state = DATA;
                DATA:  w_next_state = SPACE;
                SPACE: begin
                    if (line_in != SPI_SPACE_LVL)   w_next_state = IDLE;
                    else if (r_bit_cnt == C_LAST_BIT) w_next_state = IDLE;
                    else                            w_next_state = NEXT;
                end
                NEXT:  w_next_state = (line_in == SPI_MARK_LVL) ? DATA : IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs (datapath controls and event strobes)
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_shift_en  = 1'b0;
        w_byte_done = 1'b0;
        w_frame_err = 1'b0;
        if (!en_n_in) begin
            case (r_state)
                IDLE:  w_cnt_clr  = (line_in == SPI_MARK_LVL);
                DATA:  w_shift_en = 1'b1;
                SPACE: begin
                    if (line_in != SPI_SPACE_LVL)     w_frame_err = 1'b1;
                    else if (r_bit_cnt == C_LAST_BIT) w_byte_done = 1'b1;
                    else                              w_cnt_inc   = 1'b1;
                end
                NEXT:  w_frame_err = (line_in != SPI_MARK_LVL);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bit counter and shift register. A discarded partial byte needs no
    // explicit clearing: the next frame rewrites all eight bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_cnt_clr)      r_bit_cnt <= '0;
            else if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + 3'd1;
            // LSB first: shifting right leaves bit 0 in [0] after 8 shifts.
            if (w_shift_en)     r_shift   <= {line_in, r_shift[SPI_BITS-1:1]};
            r_frame_err <= w_frame_err;
        end
    end

    assign frame_err = r_frame_err;

`ifdef SPI_RX_FIFO_EN
    // ------------------------------------------------------------------
    // Buffered delivery
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic r_overflow;

    spi_rx_fifo #(
        .FIFO_AW (FIFO_AW),
        .WIDTH   (SPI_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_byte_done),
        .wr_data (r_shift),
        .rd_en   (rd_en),
        .rd_data (rx_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Drop only when full and no simultaneous pop frees a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_overflow <= 1'b0;
        else     r_overflow <= w_byte_done & w_full & ~(rd_en & ~w_empty);
    end

    assign rx_valid = ~w_empty;
    assign overflow = r_overflow;
`else
    // ------------------------------------------------------------------
    // Direct delivery: one-cycle valid pulse, data held until next byte
    // ------------------------------------------------------------------
    logic [SPI_BITS-1:0] r_rx_data;
    logic                r_rx_valid;
    logic                w_unused_rd_en;
    localparam int       C_UNUSED_AW = FIFO_AW;

    assign w_unused_rd_en = rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_byte_done;
            if (w_byte_done) r_rx_data <= r_shift;
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign overflow = 1'b0;
`endif

endmodule : spi_frame_rx
`default_nettype wire

// File: doc/spi_frame_rx.md
# spi_frame_rx

Receive-side decoder for the serial byte line our SPI transmitter drives. It sits directly downstream of the transmitter on the same clock. It qualifies the line with the active-low enable and decodes each bit from its three-cycle mark/data/space symbol, LSB first. It reassembles bytes and hands them to the consumer (cipher core) through a small buffer. Malformed symbols are flagged, and partial bytes are discarded on abort.

## Interface
- FIFO_AW, 2, log2 of byte buffer depth (4 entries); used only with SPI_RX_FIFO_EN
- clk  in  1  system clock; same clock that drives the transmitter
- rst  in  1  asynchronous, active-high reset
- line_in  in  1  serial data line
- en_n_in  in  1  transmitter enable; low means a frame may be in progress
- rd_en  in  1  consumer pop strobe (FIFO build only)
- rx_data  out  8  received byte
- rx_valid  out  1  byte available on rx_data
- frame_err  out  1  one-cycle pulse on a malformed symbol
- overflow  out  1  one-cycle pulse when a completed byte is dropped because the buffer is full

## Operation
- Line format per bit, one clk each:
  - MARK: line = 1
  - DATA: line = bit
  - SPACE: line = 0
- 8 bits per byte, LSB first, giving 24 cycles.
- The transmitter inserts at least one idle 0 cycle between bytes.
- FSM states: IDLE, DATA, SPACE, NEXT. A 3-bit bit counter and an 8-bit shift register (shift right, new bit into [7]) support the FSM.
- IDLE:
  - en_n_in = 0 and line_in = 1 → DATA, with bit counter cleared.
  - Any number of 0 cycles stay in IDLE.
- DATA:
  - Shift line_in into the shift register → SPACE.
- SPACE:
  - line_in = 1 → frame_err pulse, partial byte discarded → IDLE.
  - line_in = 0 and bit counter = 7 → byte complete → IDLE.
  - Otherwise increment the bit counter → NEXT.
- NEXT (MARK of bits 1..7):
  - line_in = 1 → DATA.
  - line_in = 0 → frame_err pulse, partial byte discarded → IDLE.
- en_n_in high in any state other than IDLE:
  - Immediate return to IDLE; partial byte discarded; no frame_err.
  - This is the transmitter's reset/hold condition.
  - en_n_in high takes priority over every line check.
- Completed byte goes to the buffer.

## Timing
- All outputs are registered.
- Reset values: rx_data = 0x00, rx_valid = 0, frame_err = 0, overflow = 0, FSM = IDLE, buffer empty.
- Latency: the edge that samples the 8th SPACE cycle writes the byte. rx_valid/rx_data reflect it in the following cycle.
- Back-to-back throughput: one byte per 25 clk. The receiver must accept the next MARK one cycle after the final SPACE.
- frame_err and overflow are single-cycle pulses and never sticky.
- Reset asserted mid-frame: immediate IDLE, buffer flushed, all outputs return to reset values asynchronously.

## Configuration
- SPI_RX_FIFO_EN defined:
  - 2^FIFO_AW-entry show-ahead buffer.
  - rx_valid = not empty; rx_data = head entry.
  - rd_en while rx_valid pops one entry; rd_en while empty is ignored.
  - Write and pop in the same cycle are both honoured, including when full.
  - A write when full (without a pop) drops the new byte and pulses overflow.
- SPI_RX_FIFO_EN undefined:
  - No buffer; rd_en ignored; overflow tied 0.
  - rx_valid is a one-cycle pulse with rx_data held until the next completed byte.

## Structure
- Shared package spi_pkg holds:
  - FSM state enum (IDLE, DATA, SPACE, NEXT)
  - SPI_BITS = 8
  - symbol phase constants, also reused by the transmitter
- One sub-module: spi_rx_fifo (parameterised by FIFO_AW; synchronous write/pop, full/empty flags, same async reset). Instantiated only under SPI_RX_FIFO_EN.

## Test plan
- Single byte 0xA5:
  - Stimulus: en_n_in = 0, line 110 100 110 100 100 110 100 110.
  - Response: rx_valid high next cycle with rx_data = 0xA5; frame_err never asserts.
- Back-to-back bytes:
  - Stimulus: 0x00 then 0xFF with a single idle 0 cycle between.
  - Response: both bytes received in order, 25 clk apart.
- Framing error:
  - Stimulus: bit 3 SPACE driven as 1.
  - Response: frame_err pulses once; no byte produced; the following clean 0x3C decodes correctly.
- Abort:
  - Stimulus: en_n_in raised after bit 4 DATA, then a fresh frame 0x81 sent.
  - Response: only 0x81 is delivered; no frame_err.
- FIFO build:
  - Stimulus: 5 bytes (0x01..0x05) with rd_en held low and FIFO_AW = 2.
  - Response: 4 stored; overflow pulses on byte 5; pops return 0x01..0x04, then rx_valid = 0.
- Async reset:
  - Stimulus: rst asserted mid-byte with 2 entries buffered.
  - Response: rx_valid = 0 immediately; the next clean frame decodes normally.
